pll_lock_reset_seq: RTL and testbench

Consumer end of the fabric CCC's lock interface. It monitors the PLL lock signal and a user reset, and sequences a clean, synchronous-deassert fabric reset in the PLL output clock domain. Lock loss re-asserts reset and is logged for software. It sits directly after the CCC and drives the reset of the processor subsystem and AHB/APB fabric.

---
 rtl/pll_lock_reset_seq_pkg.sv | 25 ++
 rtl/pll_lock_reset_seq_if.sv | 33 +++
 rtl/pll_lock_reset_seq_sync.sv | 28 ++
 rtl/pll_lock_reset_seq.sv | 137 +++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_lock_reset_seq_pkg.sv
// Purpose : shared state encoding and latency helper for the PLL-lock reset sequencer.
// Latency : n/a (types and a constant function only).
// Backpress: n/a.
//
// Contents:
//   seq_state_t      - 2-bit sequencer state, also exported on STATE for debug.
//   release_latency  - clock edges from the first edge sampling PLL_LOCK=1 to FABRIC_RESET_N=1.
package pll_lock_reset_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_t;

    // The synchronizer adds sync_stages edges. The FSM then needs one edge to leave WAIT_LOCK,
    // lock_stable edges in STABILIZE and reset_hold edges in HOLD.
    function automatic int release_latency(input int sync_stages,
                                           input int lock_stable,
                                           input int reset_hold);
        return sync_stages + 1 + lock_stable + reset_hold;
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_if.sv
// Purpose : groups the lock/reset inputs and the status/reset outputs of the sequencer.
// Latency : n/a (wiring only).
// Backpress: none; level and pulse signals only, no handshake.
//
// Signals:
//   PLL_LOCK, EXT_RST_N   - asynchronous inputs, synchronized inside the sequencer.
//   CLEAR_STATUS          - synchronous one-cycle pulse that clears LOCK_LOST and LOSS_CNT.
//   FABRIC_RESET_N, READY - registered release outputs, high only in RUN.
//   LOCK_LOST, LOSS_CNT   - sticky loss flag and saturating loss counter.
//   STATE                 - current sequencer state, for debug.
//   modport master drives the inputs (board/CCC side); modport slave is the sequencer.
interface pll_lock_reset_seq_if #(
    parameter int LOSS_CNT_WIDTH = 8
);
    logic                      PLL_LOCK;
    logic                      EXT_RST_N;
    logic                      CLEAR_STATUS;
    logic                      FABRIC_RESET_N;
    logic                      READY;
    logic                      LOCK_LOST;
    logic [LOSS_CNT_WIDTH-1:0] LOSS_CNT;
    logic [1:0]                STATE;

    modport master (
        output PLL_LOCK, EXT_RST_N, CLEAR_STATUS,
        input  FABRIC_RESET_N, READY, LOCK_LOST, LOSS_CNT, STATE
    );

    modport slave (
        input  PLL_LOCK, EXT_RST_N, CLEAR_STATUS,
        output FABRIC_RESET_N, READY, LOCK_LOST, LOSS_CNT, STATE
    );
endinterface

// File: rtl/pll_lock_reset_seq_sync.sv
// Purpose : N-stage single-bit synchronizer with asynchronous active-low clear to 0.
// Latency : STAGES clock edges from d to q.
// Backpress: none.
//
// Ports: clk, rst_n (async clear), d (asynchronous input), q (synchronized output).
// STAGES must be at least 2.
module pll_lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Purpose : sequences a synchronous-deassert fabric reset from PLL lock and a user reset; logs lock loss.
// Latency : release SYNC_STAGES+1+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES edges after lock; re-assert SYNC_STAGES+1 edges after a drop.
// Backpress: none; all outputs are registered levels.
//
// Ports: CLK (CCC OUT0), RESETN (async active-low clear of every flop),
//        bus (pll_lock_reset_seq_if.slave): PLL_LOCK/EXT_RST_N/CLEAR_STATUS in,
//        FABRIC_RESET_N/READY/LOCK_LOST/LOSS_CNT/STATE out.
module pll_lock_reset_seq
    import pll_lock_reset_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int CNT_WIDTH          = 16,
    parameter int LOSS_CNT_WIDTH     = 8
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    pll_lock_reset_seq_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0]      STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]      HOLD_LAST   = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
    localparam logic [LOSS_CNT_WIDTH-1:0] LOSS_ONE    = LOSS_CNT_WIDTH'(1);

    logic lock_s;
    logic ext_s;

    seq_state_t                state;
    logic [CNT_WIDTH-1:0]      cnt;
    logic                      fabric_reset_n_q;
    logic                      ready_q;
    logic                      lock_lost_q;
    logic [LOSS_CNT_WIDTH-1:0] loss_cnt_q;

    pll_lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (CLK),
        .rst_n (RESETN),
        .d     (bus.PLL_LOCK),
        .q     (lock_s)
    );

    pll_lock_sync #(.STAGES(SYNC_STAGES)) u_ext_sync (
        .clk   (CLK),
        .rst_n (RESETN),
        .d     (bus.EXT_RST_N),
        .q     (ext_s)
    );

    // Release outputs are assigned 1 only on the branches whose next state is RUN, so they are
    // the registered form of (next_state == RUN) without a separate next-state network.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state            <= ST_WAIT_LOCK;
            cnt              <= '0;
            fabric_reset_n_q <= 1'b0;
            ready_q          <= 1'b0;
            lock_lost_q      <= 1'b0;
            loss_cnt_q       <= '0;
        end else begin
            fabric_reset_n_q <= 1'b0;
            ready_q          <= 1'b0;

            // A loss logged in RUN below overrides this clear in the same cycle.
            if (bus.CLEAR_STATUS) begin
                lock_lost_q <= 1'b0;
                loss_cnt_q  <= '0;
            end

            case (state)
                ST_WAIT_LOCK: begin
                    if (lock_s && ext_s) begin
                        state <= ST_STABILIZE;
                        cnt   <= '0;
                    end
                end

                ST_STABILIZE: begin
                    // Any glitch restarts the whole sequence.
                    if (!(lock_s && ext_s)) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end

                ST_HOLD: begin
                    if (!(lock_s && ext_s)) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state            <= ST_RUN;
                        cnt              <= '0;
                        fabric_reset_n_q <= 1'b1;
                        ready_q          <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end

                ST_RUN: begin
                    // Lock loss takes priority over a simultaneous user reset so it is always logged.
                    if (!lock_s) begin
                        state       <= ST_WAIT_LOCK;
                        lock_lost_q <= 1'b1;
                        if (bus.CLEAR_STATUS) begin
                            loss_cnt_q <= LOSS_ONE;
                        end else if (loss_cnt_q != '1) begin
                            loss_cnt_q <= loss_cnt_q + LOSS_ONE;
                        end
                    end else if (!ext_s) begin
                        state <= ST_WAIT_LOCK;
                    end else begin
                        fabric_reset_n_q <= 1'b1;
                        ready_q          <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_WAIT_LOCK;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.FABRIC_RESET_N = fabric_reset_n_q;
    assign bus.READY          = ready_q;
    assign bus.LOCK_LOST      = lock_lost_q;
    assign bus.LOSS_CNT       = loss_cnt_q;
    assign bus.STATE          = state;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Purpose : self-checking bench for pll_lock_reset_seq against a streak-based reference model.
// Latency : n/a.
// Backpress: n/a.
module tb_pll_lock_reset_seq;
    import pll_lock_reset_pkg::*;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int RHC  = 4;
    localparam int CW   = 16;
    localparam int LW   = 2;
    localparam int RUN_AT = 1 + LSC + RHC;   // consecutive good synced samples that reach RUN
    localparam int MAXC   = (1 << LW) - 1;

    logic CLK    = 1'b0;
    logic RESETN = 1'b1;
    always #5 CLK = ~CLK;

    pll_lock_reset_seq_if #(.LOSS_CNT_WIDTH(LW)) bus ();

    pll_lock_reset_seq #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LSC),
        .RESET_HOLD_CYCLES  (RHC),
        .CNT_WIDTH          (CW),
        .LOSS_CNT_WIDTH     (LW)
    ) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the sequencer state is a pure function of how many consecutive edges the
    // synchronized lock and user reset have both been high. Synchronizers are pure delays.
    bit m_lock_h [SYNC];
    bit m_ext_h  [SYNC];
    int m_streak = 0;
    bit m_lost   = 1'b0;
    int m_cnt    = 0;
    bit m_ls, m_es, m_was_run;

    function automatic int m_state();
        if (m_streak == 0)              return 0;
        else if (m_streak <= LSC)       return 1;
        else if (m_streak <= LSC + RHC) return 2;
        else                            return 3;
    endfunction

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int k = 0; k < SYNC; k++) begin
                m_lock_h[k] = 1'b0;
                m_ext_h[k]  = 1'b0;
            end
            m_streak = 0;
            m_lost   = 1'b0;
            m_cnt    = 0;
        end else begin
            m_ls      = m_lock_h[SYNC-1];
            m_es      = m_ext_h[SYNC-1];
            m_was_run = (m_streak >= RUN_AT);
            if (m_was_run && !m_ls) begin
                m_lost = 1'b1;
                m_cnt  = bus.CLEAR_STATUS ? 1 : ((m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1);
            end else if (bus.CLEAR_STATUS) begin
                m_lost = 1'b0;
                m_cnt  = 0;
            end
            if (m_ls && m_es) m_streak = (m_streak >= RUN_AT) ? RUN_AT : m_streak + 1;
            else              m_streak = 0;
            for (int k = SYNC - 1; k > 0; k--) begin
                m_lock_h[k] = m_lock_h[k-1];
                m_ext_h[k]  = m_ext_h[k-1];
            end
            m_lock_h[0] = bus.PLL_LOCK;
            m_ext_h[0]  = bus.EXT_RST_N;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        check("cyc_state", {30'd0, bus.STATE}, m_state());
        check("cyc_fabric_reset_n", {31'd0, bus.FABRIC_RESET_N}, (m_state() == 3) ? 1 : 0);
        check("cyc_ready", {31'd0, bus.READY}, (m_state() == 3) ? 1 : 0);
        check("cyc_lock_lost", {31'd0, bus.LOCK_LOST}, {31'd0, m_lost});
        check("cyc_loss_cnt", {30'd0, bus.LOSS_CNT}, m_cnt);
    end

    // Inputs change 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    // Counts edges until FABRIC_RESET_N reaches val; 0 means the bound expired.
    task automatic wait_frn(input logic val, input int limit, output int edges);
        edges = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge CLK);
            #1;
            if (bus.FABRIC_RESET_N === val) begin
                edges = i;
                break;
            end
        end
        #1;
    endtask

    logic [1:0] st [1:15];
    logic       fr [1:15];
    int e;
    int first_rel;

    initial begin
        bus.PLL_LOCK     = 1'b0;
        bus.EXT_RST_N    = 1'b1;
        bus.CLEAR_STATUS = 1'b0;
        #1 RESETN = 1'b0;
        #1;
        check("rst_fabric_reset_n", {31'd0, bus.FABRIC_RESET_N}, 0);
        check("rst_ready", {31'd0, bus.READY}, 0);
        check("rst_state", {30'd0, bus.STATE}, 0);
        check("rst_lock_lost", {31'd0, bus.LOCK_LOST}, 0);
        check("rst_loss_cnt", {30'd0, bus.LOSS_CNT}, 0);
        #11 RESETN = 1'b1;
        tick(3);

        // 1: lock rise to release, state walk
        bus.PLL_LOCK = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge CLK);
            #1;
            st[i] = bus.STATE;
            fr[i] = bus.FABRIC_RESET_N;
        end
        #1;
        first_rel = 0;
        for (int i = 15; i >= 1; i--) if (fr[i] === 1'b1) first_rel = i;
        check("t1_latency", first_rel, 15);
        check("t1_latency_pkg", first_rel, release_latency(SYNC, LSC, RHC));
        check("t1_state_e2", {30'd0, st[2]}, 0);
        check("t1_state_e3", {30'd0, st[3]}, 1);
        check("t1_state_e10", {30'd0, st[10]}, 1);
        check("t1_state_e11", {30'd0, st[11]}, 2);
        check("t1_state_e14", {30'd0, st[14]}, 2);
        check("t1_state_e15", {30'd0, st[15]}, 3);
        check("t1_ready", {31'd0, bus.READY}, 1);

        // 2: lock loss in RUN for 5 cycles
        tick(2);
        bus.PLL_LOCK = 1'b0;
        wait_frn(1'b0, 10, e);
        check("t2_fall_latency", e, 3);
        check("t2_lock_lost", {31'd0, bus.LOCK_LOST}, 1);
        check("t2_loss_cnt", {30'd0, bus.LOSS_CNT}, 1);
        tick(2);
        bus.PLL_LOCK = 1'b1;
        wait_frn(1'b1, 40, e);
        check("t2_relock_latency", e, 15);

        // 3: glitch during STABILIZE restarts the sequence
        bus.CLEAR_STATUS = 1'b1;
        tick(1);
        bus.CLEAR_STATUS = 1'b0;
        check("t3_clear_lost", {31'd0, bus.LOCK_LOST}, 0);
        check("t3_clear_cnt", {30'd0, bus.LOSS_CNT}, 0);
        bus.PLL_LOCK = 1'b0;
        tick(6);
        bus.CLEAR_STATUS = 1'b1;
        tick(1);
        bus.CLEAR_STATUS = 1'b0;
        bus.PLL_LOCK = 1'b1;
        tick(8);
        check("t3_in_stabilize", {30'd0, bus.STATE}, 1);
        bus.PLL_LOCK = 1'b0;
        tick(3);
        check("t3_back_to_wait", {30'd0, bus.STATE}, 0);
        bus.PLL_LOCK = 1'b1;
        wait_frn(1'b1, 40, e);
        check("t3_release_latency", e, 15);
        check("t3_no_loss", {31'd0, bus.LOCK_LOST}, 0);

        // 4: user reset in RUN, then loss counter saturation
        tick(2);
        bus.EXT_RST_N = 1'b0;
        wait_frn(1'b0, 10, e);
        check("t4_ext_fall_latency", e, 3);
        check("t4_ext_no_loss", {31'd0, bus.LOCK_LOST}, 0);
        bus.EXT_RST_N = 1'b1;
        wait_frn(1'b1, 40, e);
        check("t4_ext_release_latency", e, 15);
        for (int n = 0; n < 5; n++) begin
            bus.PLL_LOCK = 1'b0;
            tick(5);
            bus.PLL_LOCK = 1'b1;
            wait_frn(1'b1, 40, e);
            tick(1);
        end
        check("t4_sat_cnt", {30'd0, bus.LOSS_CNT}, 3);
        check("t4_sat_lost", {31'd0, bus.LOCK_LOST}, 1);

        // 5: clear coinciding with a logged loss, then a lone clear
        bus.PLL_LOCK = 1'b0;
        tick(2);
        bus.CLEAR_STATUS = 1'b1;
        tick(1);
        bus.CLEAR_STATUS = 1'b0;
        check("t5_coinc_lost", {31'd0, bus.LOCK_LOST}, 1);
        check("t5_coinc_cnt", {30'd0, bus.LOSS_CNT}, 1);
        check("t5_coinc_frn", {31'd0, bus.FABRIC_RESET_N}, 0);
        bus.PLL_LOCK = 1'b1;
        wait_frn(1'b1, 40, e);
        tick(3);
        bus.CLEAR_STATUS = 1'b1;
        tick(1);
        bus.CLEAR_STATUS = 1'b0;
        check("t5_lone_lost", {31'd0, bus.LOCK_LOST}, 0);
        check("t5_lone_cnt", {30'd0, bus.LOSS_CNT}, 0);

        // 6: RESETN asserted during HOLD clears immediately
        bus.PLL_LOCK = 1'b0;
        tick(5);
        check("t6_loss_before_rst", {30'd0, bus.LOSS_CNT}, 1);
        bus.PLL_LOCK = 1'b1;
        tick(13);
        check("t6_in_hold", {30'd0, bus.STATE}, 2);
        #1 RESETN = 1'b0;
        #1;
        check("t6_rst_state", {30'd0, bus.STATE}, 0);
        check("t6_rst_frn", {31'd0, bus.FABRIC_RESET_N}, 0);
        check("t6_rst_ready", {31'd0, bus.READY}, 0);
        check("t6_rst_lost", {31'd0, bus.LOCK_LOST}, 0);
        check("t6_rst_cnt", {30'd0, bus.LOSS_CNT}, 0);
        tick(2);
        RESETN = 1'b1;

        // Randomized phase, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if ($urandom_range(0, 39) == 0) bus.PLL_LOCK = ~bus.PLL_LOCK;
            if (bus.EXT_RST_N && $urandom_range(0, 79) == 0)        bus.EXT_RST_N = 1'b0;
            else if (!bus.EXT_RST_N && $urandom_range(0, 3) == 0)   bus.EXT_RST_N = 1'b1;
            bus.CLEAR_STATUS = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #1 RESETN = 1'b0;
                #2 RESETN = 1'b1;
            end
        end
        bus.CLEAR_STATUS = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
